// File: rtl/router_reg_pkg.sv
//------------------------------------------------------------------------------
// router_reg_pkg : shared router constants (byte width, header field layout)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package router_reg_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 2;
   localparam int ADDR_LSB   = 0;
   localparam int ADDR_MSB   = ADDR_LSB + ADDR_WIDTH - 1;
   localparam int LEN_LSB    = ADDR_MSB + 1;

   localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = 2'b11;

endpackage

`default_nettype wire

// File: rtl/router_reg_parity_acc.sv
//------------------------------------------------------------------------------
// router_parity_acc : running packet parity, received parity capture, err flag
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

import router_reg_pkg::*;

module router_parity_acc #(
   parameter int DATA_WIDTH = router_reg_pkg::DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  detect_add_i,
   input  logic                  lfd_state_i,
   input  logic                  ld_state_i,
   input  logic                  laf_state_i,
   input  logic                  rst_int_reg_i,
   input  logic                  pkt_valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DATA_WIDTH-1:0] hdr_i,
   output logic                  err_o
);

   logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
   logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
   logic                  err_q, err_d;

   // The laf replay never touches parity, so each payload byte is counted once.
   always_comb begin
      int_parity_d = int_parity_q;
      pkt_parity_d = pkt_parity_q;
      err_d        = err_q;
      if (detect_add_i) begin
         int_parity_d = '0;
         pkt_parity_d = '0;
         if (pkt_valid_i) err_d = 1'b0;
      end else if (lfd_state_i) begin
         int_parity_d = int_parity_q ^ hdr_i;
      end else if (ld_state_i) begin
         if (pkt_valid_i) int_parity_d = int_parity_q ^ data_i;
         else             pkt_parity_d = data_i;
      end else if (!laf_state_i && rst_int_reg_i) begin
         err_d = (int_parity_q != pkt_parity_q);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         int_parity_q <= '0;
         pkt_parity_q <= '0;
         err_q        <= 1'b0;
      end else begin
         int_parity_q <= int_parity_d;
         pkt_parity_q <= pkt_parity_d;
         err_q        <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/router_reg.sv
//------------------------------------------------------------------------------
// router_reg : router datapath register stage between the FSM and output FIFOs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

import router_reg_pkg::*;

module router_reg #(
   parameter int DATA_WIDTH = router_reg_pkg::DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_packet_valid,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  parity_done_q, parity_done_d;
   logic                  low_pkt_q, low_pkt_d;
   logic                  lfd_sel, ld_sel, laf_sel;
   logic                  unused_full;

   // Strobes are one-hot by construction; these enforce priority if they are not.
   assign lfd_sel     = lfd_state && !detect_add;
   assign ld_sel      = ld_state  && !detect_add && !lfd_state;
   assign laf_sel     = laf_state && !detect_add && !lfd_state && !ld_state;
   assign unused_full = full_state;

   always_comb begin
      hdr_d         = hdr_q;
      dout_d        = dout_q;
      hold_d        = hold_q;
      low_pkt_d     = low_pkt_q;
      parity_done_d = parity_done_q;

      if (detect_add && pkt_valid && (data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID))
         hdr_d = data_in;

      // A byte arriving while the FIFO is full is parked and replayed in laf.
      if (lfd_sel) begin
         dout_d = hdr_q;
      end else if (ld_sel) begin
         if (!fifo_full) dout_d = data_in;
         else            hold_d = data_in;
      end else if (laf_sel) begin
         dout_d = hold_q;
      end

      if (rst_int_reg)                 low_pkt_d = 1'b0;
      else if (ld_sel && !pkt_valid)   low_pkt_d = 1'b1;

      if (detect_add)                                   parity_done_d = 1'b0;
      else if (ld_sel && !pkt_valid && !fifo_full)      parity_done_d = 1'b1;
      else if (laf_sel && low_pkt_q && !parity_done_q)  parity_done_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         dout_q        <= '0;
         hdr_q         <= '0;
         hold_q        <= '0;
         parity_done_q <= 1'b0;
         low_pkt_q     <= 1'b0;
      end else begin
         dout_q        <= dout_d;
         hdr_q         <= hdr_d;
         hold_q        <= hold_d;
         parity_done_q <= parity_done_d;
         low_pkt_q     <= low_pkt_d;
      end
   end

   router_parity_acc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .clock         (clock),
      .resetn        (resetn),
      .detect_add_i  (detect_add),
      .lfd_state_i   (lfd_state),
      .ld_state_i    (ld_state),
      .laf_state_i   (laf_state),
      .rst_int_reg_i (rst_int_reg),
      .pkt_valid_i   (pkt_valid),
      .data_i        (data_in),
      .hdr_i         (hdr_q),
      .err_o         (err)
   );

   assign dout             = dout_q;
   assign parity_done      = parity_done_q;
   assign low_packet_valid = low_pkt_q;

endmodule

`default_nettype wire

// File: tb/tb_router_reg.sv
//------------------------------------------------------------------------------
// tb_router_reg : directed self-checking bench for router_reg
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_router_reg;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_DA   = 6'b100000;
   localparam logic [5:0] S_LFD  = 6'b010000;
   localparam logic [5:0] S_LD   = 6'b001000;
   localparam logic [5:0] S_LAF  = 6'b000100;
   localparam logic [5:0] S_FULL = 6'b000010;
   localparam logic [5:0] S_RST  = 6'b000001;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [7:0] dout;
   logic       parity_done, low_packet_valid, err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   router_reg dut (
      .clock            (clock),
      .resetn           (resetn),
      .pkt_valid        (pkt_valid),
      .data_in          (data_in),
      .fifo_full        (fifo_full),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .laf_state        (laf_state),
      .full_state       (full_state),
      .rst_int_reg      (rst_int_reg),
      .dout             (dout),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .err              (err)
   );

   // Apply one cycle of stimulus, then return 1 time unit after the edge.
   task automatic drive(input logic [5:0] s, input logic pv, input logic [7:0] d,
                        input logic ff);
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
      pkt_valid = pv;
      data_in   = d;
      fifo_full = ff;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL reset_pd: got %b want 0", parity_done); end
      n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lpv: got %b want 0", low_packet_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      resetn = 1'b1;
   endtask

   task automatic test_good_packet();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL good_pd_hdr: got %b want 0", parity_done); end
      drive(S_LFD, 1'b1, 8'h11, 1'b0);
      n_checks++; if (dout !== 8'h0D) begin n_fail++; $display("FAIL good_dout_hdr: got %h want 0d", dout); end
      drive(S_LD, 1'b1, 8'h11, 1'b0);
      n_checks++; if (dout !== 8'h11) begin n_fail++; $display("FAIL good_dout_p1: got %h want 11", dout); end
      drive(S_LD, 1'b1, 8'h22, 1'b0);
      n_checks++; if (dout !== 8'h22) begin n_fail++; $display("FAIL good_dout_p2: got %h want 22", dout); end
      drive(S_LD, 1'b1, 8'h33, 1'b0);
      n_checks++; if (dout !== 8'h33) begin n_fail++; $display("FAIL good_dout_p3: got %h want 33", dout); end
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL good_pd_early: got %b want 0", parity_done); end
      drive(S_LD, 1'b0, 8'h0D, 1'b0);
      n_checks++; if (dout !== 8'h0D) begin n_fail++; $display("FAIL good_dout_par: got %h want 0d", dout); end
      n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL good_pd: got %b want 1", parity_done); end
      n_checks++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL good_lpv_set: got %b want 1", low_packet_valid); end
      drive(S_RST, 1'b0, 8'h00, 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL good_err: got %b want 0", err); end
      n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL good_lpv_clr: got %b want 0", low_packet_valid); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_bad_parity();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL bad_pd_clr: got %b want 0", parity_done); end
      drive(S_LFD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h22, 1'b0);
      drive(S_LD, 1'b1, 8'h33, 1'b0);
      drive(S_LD, 1'b0, 8'hFF, 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_err_early: got %b want 0", err); end
      drive(S_RST, 1'b0, 8'h00, 1'b0);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_hold: got %b want 1", err); end
      drive(S_DA, 1'b0, 8'h0D, 1'b0);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_da_nopv: got %b want 1", err); end
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_err_clr: got %b want 0", err); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_full_stall();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      drive(S_LFD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h22, 1'b1);
      n_checks++; if (dout !== 8'h11) begin n_fail++; $display("FAIL stall_dout_hold: got %h want 11", dout); end
      for (int i = 0; i < 3; i++) begin
         drive(S_FULL, 1'b1, 8'hAA, 1'b1);
         n_checks++; if (dout !== 8'h11) begin n_fail++; $display("FAIL stall_dout_full%0d: got %h want 11", i, dout); end
      end
      drive(S_LAF, 1'b1, 8'hAA, 1'b0);
      n_checks++; if (dout !== 8'h22) begin n_fail++; $display("FAIL stall_dout_laf: got %h want 22", dout); end
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL stall_pd_laf: got %b want 0", parity_done); end
      drive(S_LD, 1'b1, 8'h33, 1'b0);
      n_checks++; if (dout !== 8'h33) begin n_fail++; $display("FAIL stall_dout_p3: got %h want 33", dout); end
      drive(S_LD, 1'b0, 8'h0D, 1'b0);
      n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL stall_pd: got %b want 1", parity_done); end
      n_checks++; if (dut.u_parity.int_parity_q !== 8'h0D) begin n_fail++; $display("FAIL stall_int_parity: got %h want 0d", dut.u_parity.int_parity_q); end
      drive(S_RST, 1'b0, 8'h00, 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %b want 0", err); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_parity_hold();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      drive(S_LFD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h22, 1'b0);
      drive(S_LD, 1'b1, 8'h33, 1'b0);
      drive(S_LD, 1'b0, 8'h0D, 1'b1);
      n_checks++; if (dout !== 8'h33) begin n_fail++; $display("FAIL phold_dout: got %h want 33", dout); end
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL phold_pd_ld: got %b want 0", parity_done); end
      n_checks++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL phold_lpv: got %b want 1", low_packet_valid); end
      drive(S_FULL, 1'b0, 8'h0D, 1'b1);
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL phold_pd_full: got %b want 0", parity_done); end
      drive(S_LAF, 1'b0, 8'h0D, 1'b0);
      n_checks++; if (dout !== 8'h0D) begin n_fail++; $display("FAIL phold_dout_laf: got %h want 0d", dout); end
      n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL phold_pd_laf: got %b want 1", parity_done); end
      drive(S_RST, 1'b0, 8'h00, 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL phold_err: got %b want 0", err); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_invalid_addr();
      drive(S_DA, 1'b1, 8'h15, 1'b0);
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
      drive(S_DA, 1'b1, 8'h0F, 1'b0);
      n_checks++; if (dut.hdr_q !== 8'h15) begin n_fail++; $display("FAIL inv_hdr: got %h want 15", dut.hdr_q); end
      n_checks++; if (dout !== 8'h0D) begin n_fail++; $display("FAIL inv_dout: got %h want 0d", dout); end
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL inv_pd: got %b want 0", parity_done); end
      n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL inv_lpv: got %b want 0", low_packet_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err: got %b want 0", err); end
      drive(S_LFD, 1'b1, 8'h00, 1'b0);
      n_checks++; if (dout !== 8'h15) begin n_fail++; $display("FAIL inv_dout_lfd: got %h want 15", dout); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_mid_reset();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      drive(S_LFD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h11, 1'b0);
      resetn = 1'b0;
      drive(S_LD, 1'b1, 8'h22, 1'b0);
      resetn = 1'b1;
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL mrst_dout: got %h want 00", dout); end
      n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL mrst_pd: got %b want 0", parity_done); end
      n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_lpv: got %b want 0", low_packet_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %b want 0", err); end
      n_checks++; if (dut.u_parity.int_parity_q !== 8'h00) begin n_fail++; $display("FAIL mrst_int_parity: got %h want 00", dut.u_parity.int_parity_q); end
      n_checks++; if (dut.hdr_q !== 8'h00) begin n_fail++; $display("FAIL mrst_hdr: got %h want 00", dut.hdr_q); end
      drive(S_DA, 1'b1, 8'h0D, 1'b0);
      drive(S_LFD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h11, 1'b0);
      drive(S_LD, 1'b1, 8'h22, 1'b0);
      drive(S_LD, 1'b1, 8'h33, 1'b0);
      drive(S_LD, 1'b0, 8'h0D, 1'b0);
      n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL mrst_pkt_pd: got %b want 1", parity_done); end
      drive(S_RST, 1'b0, 8'h00, 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mrst_pkt_err: got %b want 0", err); end
      n_checks++; if (dout !== 8'h0D) begin n_fail++; $display("FAIL mrst_pkt_dout: got %h want 0d", dout); end
      drive(S_NONE, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      resetn      = 1'b0;
      pkt_valid   = 1'b0;
      data_in     = 8'h00;
      fifo_full   = 1'b0;
      detect_add  = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      rst_int_reg = 1'b0;
      test_reset();
      test_good_packet();
      test_bad_parity();
      test_full_stall();
      test_parity_hold();
      test_invalid_addr();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/router_reg.md
Name: router_reg

Overview:
- Router datapath register stage that sits directly downstream of the router FSM and upstream of the three output FIFOs.
- Consumes the FSM state strobes and latches the header byte. It sequences header, payload and parity bytes onto dout.
- It holds one byte while the selected FIFO is full.
- It computes running packet parity and reports parity_done, low_packet_valid and err back to the FSM and top level.

Parameters:
- DATA_WIDTH, 8, byte width. Header layout is [DATA_WIDTH-1:2] payload length and [1:0] destination address.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- pkt_valid  in  1  source byte valid; deasserts on the parity byte
- data_in  in  DATA_WIDTH  source byte
- fifo_full  in  1  selected FIFO full
- detect_add  in  1  FSM in DECODE_ADDRESS
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR
- dout  out  DATA_WIDTH  byte to the FIFO write port
- parity_done  out  1  parity byte accepted
- low_packet_valid  out  1  pkt_valid fell while loading
- err  out  1  parity mismatch for the last packet

Behaviour:
- All registers update on posedge clock. When resetn=0, every output and internal register goes to 0 (dout, parity_done, low_packet_valid, err, hdr_reg, hold_reg, int_parity, pkt_parity).
- Header capture: if detect_add && pkt_valid && data_in[1:0]!=2'b11, hdr_reg<=data_in. Address 2'b11 is ignored and hdr_reg holds.
- dout update priority (first match wins):
  - lfd_state: dout<=hdr_reg
  - ld_state && !fifo_full: dout<=data_in
  - laf_state: dout<=hold_reg
  - otherwise dout holds
- dout latency is one cycle from the qualifying strobe.
- Hold register: ld_state && fifo_full gives hold_reg<=data_in, and dout is unchanged. Exactly one byte is buffered. full_state does not alter hold_reg.
- int_parity:
  - cleared on detect_add
  - lfd_state: int_parity^=hdr_reg
  - ld_state && pkt_valid: int_parity^=data_in, whether the byte went to dout or hold_reg
  - Each payload byte is counted exactly once. The laf_state replay does not re-accumulate.
  - The parity byte (pkt_valid=0) is never accumulated.
- pkt_parity: ld_state && !pkt_valid gives pkt_parity<=data_in. Cleared on detect_add.
- low_packet_valid:
  - rst_int_reg clears it (highest priority)
  - else ld_state && !pkt_valid sets it
  - else holds
- parity_done:
  - detect_add clears it
  - set on ld_state && !pkt_valid && !fifo_full
  - set on laf_state && low_packet_valid && !parity_done
  - else holds
- err: on rst_int_reg, err<=(int_parity!=pkt_parity). Cleared on detect_add && pkt_valid. Otherwise holds, so it stays visible after the packet.
- Simultaneous strobes: the FSM guarantees one-hot strobes. If more than one is high, the priority order is detect_add, lfd_state, ld_state, laf_state, rst_int_reg.
- Reset mid-packet: all state returns to 0 in one cycle and no partial parity survives.
- Parity byte arriving while fifo_full: it lands in hold_reg and parity_done stays 0. The laf_state replay then writes it to dout and sets parity_done.

Decomposition:
- Shared router package holds DATA_WIDTH, the address field width (2), the invalid address constant 2'b11 and the header field slice positions.
- One natural sub-module: router_parity_acc, which contains the int_parity/pkt_parity accumulate, compare and err logic.
- Header, hold and dout muxing stay in router_reg.

Test Plan:
- Good packet. Stimulus: header 0x0D (length 3, address 1), payload 0x11/0x22/0x33, parity 0x0D, fifo_full=0.
  Required: dout sequence 0x0D, 0x11, 0x22, 0x33, 0x0D. parity_done=1 the cycle after the parity byte. err=0 after rst_int_reg. low_packet_valid pulses high then clears on rst_int_reg.
- Bad parity. Stimulus: same packet with parity byte 0xFF.
  Required: err=1 the cycle after rst_int_reg, held until the next detect_add with pkt_valid.
- Full stall. Stimulus: fifo_full=1 during ld_state with data 0x22, then full_state for 3 cycles, then laf_state with fifo_full=0.
  Required: dout holds 0x11 through the stall, then becomes 0x22. The final int_parity equals good parity (0x0D) and err=0.
- Parity byte into hold. Stimulus: fifo_full=1 when pkt_valid falls with byte 0x0D.
  Required: parity_done stays 0 until laf_state, then dout=0x0D and parity_done=1.
- Invalid address. Stimulus: detect_add && pkt_valid with header 0x0F.
  Required: hdr_reg unchanged from the previous value and no outputs change.
- Mid-packet reset. Stimulus: resetn=0 for 1 cycle during payload byte 2.
  Required: all outputs 0 the next cycle. A following good packet completes with err=0.
